// File: rtl/move_scheduler.sv
// Per-frame movement sequencer: snapshots agent positions, time-shares the maze
// lookup port one query per active agent, and publishes per-agent direction masks.
module move_scheduler #(
  parameter int unsigned N_AGENTS = 5,
  parameter int unsigned ROM_LAT  = 2,
  parameter int unsigned POS_W    = 10
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic [N_AGENTS*POS_W-1:0] agent_x,
  input  logic [N_AGENTS*POS_W-1:0] agent_y,
  input  logic [N_AGENTS-1:0]       agent_active,
  output logic                      maze_req,
  output logic [POS_W-1:0]          maze_x,
  output logic [POS_W-1:0]          maze_y,
  input  logic                      maze_gnt,
  input  logic [3:0]                maze_dir,
  output logic [N_AGENTS*4-1:0]     avail_dir,
  output logic [N_AGENTS-1:0]       move_en,
  output logic                      sweep_busy,
  output logic                      overrun
);

  localparam int unsigned IDX_W = $clog2(N_AGENTS + 1);
  localparam int unsigned CNT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    REQ,
    WAIT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [POS_W-1:0] snap_x [N_AGENTS];
  logic [POS_W-1:0] snap_y [N_AGENTS];

  // Sweep sequencer; every output is a register updated alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      maze_req   <= 1'b0;
      maze_x     <= '0;
      maze_y     <= '0;
      avail_dir  <= '0;
      move_en    <= '0;
      sweep_busy <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < N_AGENTS; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
    end else begin
      move_en <= '0;
      if (frame_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            for (int unsigned i = 0; i < N_AGENTS; i++) begin
              snap_x[i] <= agent_x[i*POS_W +: POS_W];
              snap_y[i] <= agent_y[i*POS_W +: POS_W];
            end
            idx        <= '0;
            state      <= SELECT;
            sweep_busy <= 1'b1;
          end
        end
        SELECT: begin
          if (idx == IDX_W'(N_AGENTS)) begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
          end else if (!agent_active[idx]) begin
            idx <= idx + IDX_W'(1);
          end else begin
            state    <= REQ;
            maze_req <= 1'b1;
            maze_x   <= snap_x[idx];
            maze_y   <= snap_y[idx];
          end
        end
        REQ: begin
          if (maze_gnt) begin
            state    <= WAIT;
            maze_req <= 1'b0;
            cnt      <= CNT_W'(1);
          end
        end
        WAIT: begin
          // ROM data is valid only in the final latency cycle.
          if (cnt == CNT_W'(ROM_LAT)) begin
            avail_dir[32'(idx)*4 +: 4] <= maze_dir;
            move_en[idx]               <= 1'b1;
            idx                        <= idx + IDX_W'(1);
            state                      <= SELECT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed table, randomized sweeps
// against a timeline model, and overrun/reset sequences.
module tb_move_scheduler;

  localparam int N    = 5;
  localparam int LAT  = 2;
  localparam int PW   = 10;
  localparam int MAXC = 256;

  logic            Clk;
  logic            Reset;
  logic            frame_start;
  logic [N*PW-1:0] agent_x;
  logic [N*PW-1:0] agent_y;
  logic [N-1:0]    agent_active;
  logic            maze_req;
  logic [PW-1:0]   maze_x;
  logic [PW-1:0]   maze_y;
  logic            maze_gnt;
  logic [3:0]      maze_dir;
  logic [N*4-1:0]  avail_dir;
  logic [N-1:0]    move_en;
  logic            sweep_busy;
  logic            overrun;

  move_scheduler #(.N_AGENTS(N), .ROM_LAT(LAT), .POS_W(PW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .agent_x(agent_x), .agent_y(agent_y), .agent_active(agent_active),
    .maze_req(maze_req), .maze_x(maze_x), .maze_y(maze_y),
    .maze_gnt(maze_gnt), .maze_dir(maze_dir), .avail_dir(avail_dir),
    .move_en(move_en), .sweep_busy(sweep_busy), .overrun(overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit          gnt_arr [MAXC];
  bit          exp_req [MAXC];
  int          exp_ag  [MAXC];
  logic [N-1:0] exp_en [MAXC];
  logic [3:0]  rom_q   [MAXC];
  bit          rom_v   [MAXC];
  logic [PW-1:0] pos_x [N];
  logic [PW-1:0] pos_y [N];
  logic [3:0]  model_avail [N];

  typedef struct {
    logic [N-1:0] act;
    int           lo_start;
    int           lo_len;
    logic [3:0]   y_ghost;
    int           exp_last;
    logic [N-1:0] exp_en;
    logic [19:0]  exp_avail;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rom_f(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return x[3:0] ^ y[3:0];
  endfunction

  task automatic do_reset();
    Reset = 1'b1; frame_start = 1'b0; maze_gnt = 1'b0; maze_dir = '0;
    agent_x = '0; agent_y = '0; agent_active = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  // Builds the expected cycle timeline from the sharing rules, then drives and checks one sweep.
  task automatic run_sweep(input logic [N-1:0] act, input int lo_start, input int lo_len,
                           input bit rnd, output int last_busy, output logic [N-1:0] en_seen);
    int t, r, g, end_c;
    logic [19:0] packed_avail;
    for (int c = 0; c < MAXC; c++) begin
      gnt_arr[c] = rnd ? (($urandom_range(0, 2) != 0) || (c % 8 == 0))
                       : !((c >= lo_start) && (c < lo_start + lo_len));
      exp_req[c] = 1'b0; exp_ag[c] = 0; exp_en[c] = '0; rom_v[c] = 1'b0; rom_q[c] = '0;
    end
    t = 1;
    for (int i = 0; i < N; i++) begin
      if (!act[i]) begin
        t = t + 1;
      end else begin
        r = t + 1;
        g = r;
        while (!gnt_arr[g]) g++;
        for (int c = r; c <= g; c++) begin
          exp_req[c] = 1'b1; exp_ag[c] = i;
        end
        exp_en[g + LAT + 1][i] = 1'b1;
        model_avail[i] = rom_f(pos_x[i], pos_y[i]);
        t = g + LAT + 1;
      end
    end
    end_c = t;
    last_busy = -1;
    en_seen = '0;
    agent_active = act;
    for (int c = 0; c <= end_c + 2; c++) begin
      frame_start = (c == 0);
      if (c == 0) begin
        for (int i = 0; i < N; i++) begin
          agent_x[i*PW +: PW] = pos_x[i];
          agent_y[i*PW +: PW] = pos_y[i];
        end
      end else if (rnd) begin
        agent_x = (N*PW)'({$urandom(), $urandom()});
        agent_y = (N*PW)'({$urandom(), $urandom()});
      end else begin
        agent_x[0 +: PW] = PW'(100);
      end
      maze_gnt = gnt_arr[c];
      maze_dir = rom_v[c] ? rom_q[c] : 4'($urandom());
      @(negedge Clk);
      chk("sweep_busy", 32'(sweep_busy), 32'((c >= 1) && (c <= end_c)));
      chk("maze_req", 32'(maze_req), 32'(exp_req[c]));
      chk("move_en", 32'(move_en), 32'(exp_en[c]));
      if (exp_req[c]) begin
        chk("maze_x", 32'(maze_x), 32'(pos_x[exp_ag[c]]));
        chk("maze_y", 32'(maze_y), 32'(pos_y[exp_ag[c]]));
      end
      if (sweep_busy) last_busy = c;
      en_seen = en_seen | move_en;
      if (maze_req && maze_gnt && (c + LAT < MAXC)) begin
        rom_q[c + LAT] = rom_f(maze_x, maze_y);
        rom_v[c + LAT] = 1'b1;
      end
      @(posedge Clk); #1;
    end
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) packed_avail[i*4 +: 4] = model_avail[i];
    chk("avail_dir_model", 32'(avail_dir), 32'(packed_avail));
    chk("overrun_quiet", 32'(overrun), 32'(0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lb;
    logic [N-1:0] ens;
    vecs[0] = '{5'b11111, 0, 0, 4'h0, 21, 5'b11111, 20'hAAAA5};
    vecs[1] = '{5'b11111, 6, 7, 4'h0, 28, 5'b11111, 20'hAAAA5};
    vecs[2] = '{5'b10101, 0, 0, 4'h3, 15, 5'b10101, 20'h9A9A5};
    vecs[3] = '{5'b00000, 0, 0, 4'h0,  6, 5'b00000, 20'h9A9A5};
    vecs[4] = '{5'b01111, 2, 3, 4'h5, 21, 5'b01111, 20'h9FFF5};

    do_reset();
    repeat (10) @(posedge Clk);
    #1;
    chk("idle_req", 32'(maze_req), 32'(0));
    chk("idle_move_en", 32'(move_en), 32'(0));
    chk("idle_avail", 32'(avail_dir), 32'(0));
    chk("idle_busy", 32'(sweep_busy), 32'(0));
    chk("idle_overrun", 32'(overrun), 32'(0));
    chk("idle_maze_x", 32'(maze_x), 32'(0));

    for (int i = 0; i < N; i++) model_avail[i] = 4'h0;

    // Directed table: hand-computed sweep end, enables and final masks.
    for (int v = 0; v < 5; v++) begin
      pos_x[0] = PW'(228); pos_y[0] = PW'(1);
      pos_x[1] = PW'(10);  pos_x[2] = PW'(26); pos_x[3] = PW'(42); pos_x[4] = PW'(58);
      for (int i = 1; i < N; i++) pos_y[i] = PW'(vecs[v].y_ghost);
      run_sweep(vecs[v].act, vecs[v].lo_start, vecs[v].lo_len, 1'b0, lb, ens);
      chk("vec_last_busy", 32'(lb), 32'(vecs[v].exp_last));
      chk("vec_en_seen", 32'(ens), 32'(vecs[v].exp_en));
      chk("vec_avail", 32'(avail_dir), 32'(vecs[v].exp_avail));
    end

    // Randomized sweeps against the timeline model.
    for (int s = 0; s < 20; s++) begin
      logic [N-1:0] act;
      act = N'($urandom());
      for (int i = 0; i < N; i++) begin
        pos_x[i] = PW'($urandom());
        pos_y[i] = PW'($urandom());
      end
      run_sweep(act, 0, 0, 1'b1, lb, ens);
      chk("rnd_en_seen", 32'(ens), 32'(act));
    end

    // frame_start during the final SELECT is dropped and flags overrun.
    do_reset();
    agent_active = 5'b11111;
    for (int c = 0; c <= 26; c++) begin
      frame_start = (c == 0) || (c == 21);
      maze_gnt = 1'b1;
      maze_dir = 4'($urandom());
      @(negedge Clk);
      if (c == 21) begin
        chk("final_sel_busy", 32'(sweep_busy), 32'(1));
        chk("final_sel_overrun_pre", 32'(overrun), 32'(0));
      end
      if (c == 22) chk("final_sel_overrun", 32'(overrun), 32'(1));
      if (c >= 22) chk("final_sel_no_resweep", 32'(sweep_busy), 32'(0));
      @(posedge Clk); #1;
    end
    frame_start = 1'b0;

    // Mid-sweep frame_start then Reset mid-sweep.
    do_reset();
    agent_active = 5'b11111;
    for (int c = 0; c <= 20; c++) begin
      frame_start = (c == 0) || (c == 10);
      Reset = (c == 15);
      maze_gnt = 1'b1;
      maze_dir = 4'($urandom());
      @(negedge Clk);
      if (c == 10) chk("ovr_before", 32'(overrun), 32'(0));
      if (c == 11) begin
        chk("ovr_set", 32'(overrun), 32'(1));
        chk("ovr_busy", 32'(sweep_busy), 32'(1));
      end
      if (c == 15) chk("ovr_sticky", 32'(overrun), 32'(1));
      if (c == 16) begin
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_avail", 32'(avail_dir), 32'(0));
        chk("rst_req", 32'(maze_req), 32'(0));
        chk("rst_move_en", 32'(move_en), 32'(0));
        chk("rst_maze_x", 32'(maze_x), 32'(0));
      end
      if (c >= 16) chk("rst_idle", 32'(sweep_busy), 32'(0));
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
    frame_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
